mycpu_io_port: RTL
==================

Name: mycpu_io_port

Overview:
- Device-side responder for the CPU's IOR/IOW instructions; completes each I/O access with a wait-state handshake.
- Contains an RX FIFO, filled from an external input stream and drained by IOR, and a TX FIFO, filled by IOW and drained to an external output stream.
- Sits between the CPU control unit's I/O bus and the board-level streaming interfaces.

Parameters:
- N, 8, data width of CPU datapath and streams.
- DEPTH, 4, entries per FIFO (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- io_req  in  1  CPU I/O request; held high until io_ack
- io_we  in  1  1 = IOW (write), 0 = IOR (read); stable while io_req
- io_addr  in  1  0 = DATA, 1 = STATUS
- io_wdata  in  N  IOW data; stable while io_req
- io_rdata  out  N  IOR result, valid only while io_ack=1
- io_ack  out  1  single-cycle completion pulse
- in_valid  in  1  external input word valid
- in_data  in  N  external input word
- in_ready  out  1  RX FIFO can accept
- out_valid  out  1  TX FIFO holds a word
- out_data  out  N  TX FIFO head word
- out_ready  in  1  external sink accepts

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FSM to P_IDLE; both FIFOs emptied.
  - io_ack=0, io_rdata=0, out_valid=0, in_ready=0 during reset, 1 in the first cycle after.
  - A pending transaction is dropped; the CPU must re-issue it.
- Streams:
  - Push RX when in_valid&&in_ready. in_ready = !rx_full, registered-count based.
  - A same-cycle pop does not free space for a push (no full bypass).
  - Pop TX when out_valid&&out_ready. out_valid = !tx_empty. out_data = TX head, combinational from storage.
- FSM states P_IDLE, P_WAIT, P_ACK:
  - P_IDLE:
    - If io_req and the access can complete now, perform it (pop RX / push TX / sample status) and go to P_ACK.
    - If io_req and it cannot complete, go to P_WAIT.
    - "Cannot complete" means DATA read with RX empty, or DATA write with TX full.
  - P_WAIT: re-evaluate every cycle; on completion perform the access and go to P_ACK. Stays indefinitely (CPU stalls).
  - P_ACK:
    - io_ack=1 for exactly this cycle; io_rdata holds the registered result (0 for writes).
    - Next state P_IDLE; io_req is ignored in P_ACK. The CPU drops io_req in the cycle after ack.
- Latency: minimum 1 cycle between io_req rising (sampled in P_IDLE) and io_ack.
- STATUS read:
  - Always completes immediately; no FIFO side effects.
  - io_rdata = {zero-pad, tx_count[2:0 widened], rx_count, tx_not_full, rx_not_empty}, packed as bit0 rx_not_empty, bit1 tx_not_full, bits[N-1:2] = rx_count in low half, tx_count in high half.
  - Counts saturate at the field width.
- STATUS write: acknowledged, no effect.
- Simultaneous events:
  - CPU DATA read pop and external push on the same cycle with RX non-full: both occur, and count is unchanged.
  - CPU write push and external pop on the same cycle with TX non-full: both occur.
  - CPU read in P_WAIT completes in the cycle after the first external push lands: the pushed word is visible one cycle after in_valid&&in_ready.
- FIFO pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits. FIFO order is strict.

Decomposition:
- Shared CPU package additions:
  - io_state_t enum {P_IDLE=2'b00, P_WAIT=2'b01, P_ACK=2'b10}.
  - Constants IO_ADDR_DATA=1'b0, IO_ADDR_STATUS=1'b1.
  - Status bit-index constants.
- One sub-module: mycpu_fifo (params N, DEPTH; push/pop/full/empty/count/head), instantiated twice, for RX and TX.

Test Plan:
- Reset then STATUS read (N=8, DEPTH=4) -> io_ack 1 cycle after req; io_rdata=8'b0000_0010 (rx empty, tx not full); in_ready=1, out_valid=0.
- Push 0x3C,0x91 via in_stream, then two IOR DATA -> io_rdata 0x3C then 0x91, each with single-cycle io_ack; STATUS then shows rx_not_empty=0.
- IOR DATA with RX empty -> FSM in P_WAIT, io_ack stays 0 for 10 cycles; drive in_valid with 0xA5 -> io_ack with io_rdata=0xA5 two cycles later.
- Four IOW 0x01..0x04 with out_ready=0 -> TX full, fifth IOW 0x05 stalls in P_WAIT; pulse out_ready one cycle -> out_data 0x01 consumed, fifth IOW acked; drain yields 0x02,0x03,0x04,0x05.
- Fill RX with 4 words -> in_ready=0; simultaneous IOR pop and in_valid -> no push that cycle; next cycle in_ready=1 and the push succeeds; order preserved.
- Assert rst during P_WAIT (read on empty RX) -> next cycle FSM P_IDLE, io_ack=0, FIFOs empty; the held io_req then restarts the access from P_IDLE.

Source files
------------

// File: rtl/mycpu_io_port_pkg.sv
// Shared CPU I/O port types: bus FSM states, register addresses, STATUS bit layout.
// Declarations only; no timing or backpressure of its own.
package mycpu_io_port_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'b00,
    P_WAIT = 2'b01,
    P_ACK  = 2'b10
  } io_state_t;

  localparam logic IO_ADDR_DATA   = 1'b0;
  localparam logic IO_ADDR_STATUS = 1'b1;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_NOT_FULL  = 1;
  localparam int ST_COUNT_LSB    = 2;

  // Width of each count field; the bits above the two flags are split evenly.
  function automatic int status_half(input int n);
    return (n - ST_COUNT_LSB) / 2;
  endfunction

endpackage

// File: rtl/mycpu_fifo.sv
// Synchronous FIFO with a registered count. Head is combinational from storage.
// Push is ignored when full and pop when empty; a same-cycle pop does not make room for a push.
module mycpu_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [N-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [N-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointer increments wrap by truncation.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mycpu_io_port.sv
// Device-side responder for CPU IOR/IOW: RX FIFO drained by reads, TX FIFO filled by writes.
// io_ack one cycle after an accepted request; DATA accesses wait in P_WAIT on empty RX / full TX.
module mycpu_io_port
  import mycpu_io_port_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         io_req,
  input  logic         io_we,
  input  logic         io_addr,
  input  logic [N-1:0] io_wdata,
  output logic [N-1:0] io_rdata,
  output logic         io_ack,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int HALF = status_half(N);

  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] rx_count;
  logic [N-1:0]  rx_head;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_count;

  io_state_t     state_q, state_d;
  logic          io_ack_q, io_ack_d;
  logic [N-1:0]  io_rdata_q, io_rdata_d;
  logic [N-1:0]  status;
  logic          is_data;
  logic          can_complete;

  assign in_ready  = !rx_full && !rst;
  assign rx_push   = in_valid && in_ready;
  assign out_valid = !tx_empty && !rst;
  assign tx_pop    = out_valid && out_ready;
  assign io_ack    = io_ack_q;
  assign io_rdata  = io_rdata_q;

  mycpu_fifo #(.N(N), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (in_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .head      (rx_head)
  );

  mycpu_fifo #(.N(N), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (io_wdata),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (out_data)
  );

  function automatic logic [HALF-1:0] sat_count(input logic [CW-1:0] c);
    if (CW > HALF && (c >> HALF) != '0) begin
      return '1;
    end
    return HALF'(c);
  endfunction

  always_comb begin
    status                                = '0;
    status[ST_RX_NOT_EMPTY]               = !rx_empty;
    status[ST_TX_NOT_FULL]                = !tx_full;
    status[ST_COUNT_LSB +: HALF]          = sat_count(rx_count);
    status[ST_COUNT_LSB + HALF +: HALF]   = sat_count(tx_count);
  end

  // Access decisions use registered FIFO counts, so a word pushed this cycle
  // becomes readable only on the next one.
  always_comb begin
    is_data      = (io_addr == IO_ADDR_DATA);
    can_complete = !(is_data && !io_we && rx_empty) && !(is_data && io_we && tx_full);
    state_d      = state_q;
    io_ack_d     = 1'b0;
    io_rdata_d   = '0;
    rx_pop       = 1'b0;
    tx_push      = 1'b0;
    case (state_q)
      P_IDLE, P_WAIT: begin
        if (io_req) begin
          if (can_complete) begin
            state_d  = P_ACK;
            io_ack_d = 1'b1;
            rx_pop   = is_data && !io_we;
            tx_push  = is_data && io_we;
            if (!io_we) begin
              io_rdata_d = is_data ? rx_head : status;
            end
          end else begin
            state_d = P_WAIT;
          end
        end else begin
          state_d = P_IDLE;
        end
      end
      P_ACK:   state_d = P_IDLE;
      default: state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= P_IDLE;
      io_ack_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      io_ack_q   <= io_ack_d;
      io_rdata_q <= io_rdata_d;
    end
  end

endmodule
